// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared Wishbone bus widths and the arbiter's state encoding.
// Contents    : WB_AW / WB_DW / WB_SW  address, data and byte-select widths
//               state_t                 arbiter FSM state (IDLE / BUSY)
// Revision    : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int WB_AW = 32;   // address width
  localparam int WB_DW = 32;   // data width
  localparam int WB_SW = 4;    // byte-select width

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority picker. Returns the first
//               requester strictly above the previous winner, wrapping to
//               the lowest requester when nothing above is asking.
// Ports       : req   in   NUM_M  request vector
//               last  in   NUM_M  one-hot previous winner
//               gnt   out  NUM_M  one-hot next winner (zero if no request)
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick
  import wb_pkg::*;
#(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [NUM_M-1:0] last,
  output logic [NUM_M-1:0] gnt
);

  localparam logic [NUM_M-1:0] c_one = {{(NUM_M-1){1'b0}}, 1'b1};

  logic [NUM_M-1:0] w_hi_mask;
  logic [NUM_M-1:0] w_req_hi;
  logic [NUM_M-1:0] w_cand;

  // Bits strictly above the one-hot 'last'. When last is the top bit the
  // shift overflows to zero, the subtraction gives all ones and the mask
  // becomes empty, which is exactly the wrap-around case.
  assign w_hi_mask = ~((last << 1) - c_one);
  assign w_req_hi  = req & w_hi_mask;

  // Prefer requesters above the previous winner, otherwise wrap.
  assign w_cand = (|w_req_hi) ? w_req_hi : req;

  // Isolate the lowest set bit.
  assign gnt = w_cand & (~w_cand + c_one);

endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_arbiter
// Description : Shares one Wishbone slave bus among NUM_M masters with
//               round-robin arbitration. The grant is held for the whole
//               master cycle; bus signals are muxed from the granted master
//               and terminations are steered back to it only. A watchdog
//               forces a one-cycle error when a strobed transfer stalls.
// Ports       : clk                  in   system clock, rising edge
//               rst                  in   async reset, active low
//               m_cyc/stb/we_i       in   per-master control
//               m_adr/sel/dat_i      in   per-master payload (packed, k-th
//                                         master in slice k)
//               m_gnt_o              out  one-hot registered grant
//               m_ack/err/rty_o      out  terminations, granted master only
//               m_dat_o              out  read data broadcast
//               s_cyc/stb/we/adr/sel/dat_o  out  slave bus
//               s_dat/ack/err/rty_i  in   slave response
// Revision    : 1.0  initial release
// ============================================================================
module wb_bus_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_M-1:0]       m_cyc_i,
  input  logic [NUM_M-1:0]       m_stb_i,
  input  logic [NUM_M-1:0]       m_we_i,
  input  logic [NUM_M*WB_AW-1:0] m_adr_i,
  input  logic [NUM_M*WB_SW-1:0] m_sel_i,
  input  logic [NUM_M*WB_DW-1:0] m_dat_i,
  output logic [NUM_M-1:0]       m_gnt_o,
  output logic [NUM_M-1:0]       m_ack_o,
  output logic [NUM_M-1:0]       m_err_o,
  output logic [NUM_M-1:0]       m_rty_o,
  output logic [WB_DW-1:0]       m_dat_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [WB_AW-1:0]       s_adr_o,
  output logic [WB_SW-1:0]       s_sel_o,
  output logic [WB_DW-1:0]       s_dat_o,
  input  logic [WB_DW-1:0]       s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_rty_i
);

  localparam int               IW         = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT - 1);
  localparam logic [NUM_M-1:0] c_last_rst = {1'b1, {(NUM_M-1){1'b0}}};

  state_t            r_state;
  logic [NUM_M-1:0]  r_gnt;
  logic [IW-1:0]     r_gidx;
  logic [NUM_M-1:0]  r_last;
  logic [TO_W-1:0]   r_wd_cnt;
  logic              r_to_flag;

  logic [NUM_M-1:0]  w_pick;
  logic [IW-1:0]     w_pick_idx;
  logic              w_busy;
  logic              w_term;
  logic              w_stall;

  logic [WB_AW-1:0]  w_adr_arr [NUM_M];
  logic [WB_SW-1:0]  w_sel_arr [NUM_M];
  logic [WB_DW-1:0]  w_dat_arr [NUM_M];

  // --------------------------------------------------------------------------
  // Split the packed per-master payload buses into arrays for indexed muxing.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_M; k++) begin : g_unpack
    assign w_adr_arr[k] = m_adr_i[k*WB_AW +: WB_AW];
    assign w_sel_arr[k] = m_sel_i[k*WB_SW +: WB_SW];
    assign w_dat_arr[k] = m_dat_i[k*WB_DW +: WB_DW];
  end

  // --------------------------------------------------------------------------
  // Round-robin choice of the next master.
  // --------------------------------------------------------------------------
  rr_pick #(
    .NUM_M (NUM_M)
  ) u_rr_pick (
    .req  (m_cyc_i),
    .last (r_last),
    .gnt  (w_pick)
  );

  // One-hot to index, walking a shifted copy so only constant bit selects
  // are needed.
  always_comb begin
    logic [NUM_M-1:0] v_scan;
    w_pick_idx = '0;
    v_scan     = w_pick;
    for (int k = 0; k < NUM_M; k++) begin
      if (v_scan[0]) begin
        w_pick_idx = IW'(k);
      end
      v_scan = v_scan >> 1;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration FSM. A release always lands in IDLE, so back-to-back grants
  // are separated by one dead cycle and a new request on the release cycle
  // is only considered on the following IDLE cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_last  <= c_last_rst;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|m_cyc_i) begin
            r_gnt   <= w_pick;
            r_gidx  <= w_pick_idx;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!m_cyc_i[r_gidx]) begin
            r_gnt   <= '0;
            r_last  <= r_gnt;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign w_busy  = (r_state == ST_BUSY);
  assign m_gnt_o = r_gnt;

  // --------------------------------------------------------------------------
  // Bus mux: everything is forced low while no grant is held.
  // --------------------------------------------------------------------------
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (w_busy) begin
      s_cyc_o = m_cyc_i[r_gidx];
      s_stb_o = m_stb_i[r_gidx];
      s_we_o  = m_we_i[r_gidx];
      s_adr_o = w_adr_arr[r_gidx];
      s_sel_o = w_sel_arr[r_gidx];
      s_dat_o = w_dat_arr[r_gidx];
    end
  end

  // Terminations reach only the granted master; r_gnt is zero when idle.
  assign m_ack_o = r_gnt & {NUM_M{s_ack_i}};
  assign m_rty_o = r_gnt & {NUM_M{s_rty_i}};
  assign m_err_o = r_gnt & {NUM_M{s_err_i | r_to_flag}};
  assign m_dat_o = s_dat_i;

  // --------------------------------------------------------------------------
  // Watchdog. A slave termination on the expiry cycle takes precedence, so
  // the forced error is never stacked on a real one. The counter restarts
  // as the flag is raised so a continuing stall fires again TIMEOUT cycles
  // later.
  // --------------------------------------------------------------------------
  assign w_term  = s_ack_i | s_err_i | s_rty_i;
  assign w_stall = w_busy & s_stb_o & ~w_term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else if (!w_stall) begin
      r_wd_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else if (r_wd_cnt == c_to_last) begin
      r_wd_cnt  <= '0;
      r_to_flag <= 1'b1;
    end else begin
      r_wd_cnt  <= r_wd_cnt + 1'b1;
      r_to_flag <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_arbiter
// Description : Self-checking bench for wb_bus_arbiter (NUM_M=2, TIMEOUT=16).
//               A behavioural model tracks the granted master, the rotation
//               pointer and the run length of stalled cycles; outputs are
//               compared against it every falling edge. Directed sequences
//               add hand-computed literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_bus_arbiter;

  localparam int NUM_M   = 2;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NUM_M-1:0]   m_cyc = '0;
  logic [NUM_M-1:0]   m_stb = '0;
  logic [NUM_M-1:0]   m_we  = '0;
  logic [NUM_M*32-1:0] m_adr = '0;
  logic [NUM_M*4-1:0]  m_sel = '0;
  logic [NUM_M*32-1:0] m_dat = '0;
  logic [NUM_M-1:0]   m_gnt_o, m_ack_o, m_err_o, m_rty_o;
  logic [31:0]        m_dat_o;
  logic               s_cyc_o, s_stb_o, s_we_o;
  logic [31:0]        s_adr_o, s_dat_o;
  logic [3:0]         s_sel_o;
  logic [31:0]        s_dat_i = '0;
  logic               s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;
  int err_q[$];

  wb_bus_arbiter #(
    .NUM_M   (NUM_M),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_sel_i (m_sel),
    .m_dat_i (m_dat),
    .m_gnt_o (m_gnt_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .m_dat_o (m_dat_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_sel_o (s_sel_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .s_rty_i (s_rty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc_n);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: who owns the bus, who owned it last, and how many
  // consecutive stalled strobe cycles have elapsed.
  // --------------------------------------------------------------------------
  int mg    = -1;
  int mlast = NUM_M - 1;
  int run   = 0;
  bit mto   = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    bit stall;
    bit found;
    int c;
    if (!rst) begin
      mg = -1; mlast = NUM_M - 1; run = 0; mto = 1'b0;
    end else begin
      stall = (mg >= 0) && m_stb[mg] && !(s_ack || s_err || s_rty);
      if (stall) begin
        run = run + 1;
        mto = (run == TIMEOUT);
        if (mto) run = 0;
      end else begin
        run = 0;
        mto = 1'b0;
      end
      if (mg < 0) begin
        found = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
          c = (mlast + i) % NUM_M;
          if (!found && m_cyc[c]) begin
            mg = c;
            found = 1'b1;
          end
        end
      end else if (!m_cyc[mg]) begin
        mlast = mg;
        mg = -1;
      end
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin : compare
    logic [NUM_M-1:0] eg;
    logic             e_cyc, e_stb, e_we;
    logic [31:0]      e_adr, e_dat;
    logic [3:0]       e_sel;
    eg = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
    e_adr = '0; e_dat = '0; e_sel = '0;
    if (mg >= 0) begin
      eg[mg] = 1'b1;
      e_cyc  = m_cyc[mg];
      e_stb  = m_stb[mg];
      e_we   = m_we[mg];
      e_adr  = m_adr[mg*32 +: 32];
      e_sel  = m_sel[mg*4 +: 4];
      e_dat  = m_dat[mg*32 +: 32];
    end
    chk("m_gnt",   64'(m_gnt_o), 64'(eg));
    chk("m_ack",   64'(m_ack_o), 64'(s_ack ? eg : '0));
    chk("m_rty",   64'(m_rty_o), 64'(s_rty ? eg : '0));
    chk("m_err",   64'(m_err_o), 64'((s_err || mto) ? eg : '0));
    chk("m_dat_o", 64'(m_dat_o), 64'(s_dat_i));
    chk("s_cyc",   64'(s_cyc_o), 64'(e_cyc));
    chk("s_stb",   64'(s_stb_o), 64'(e_stb));
    chk("s_we",    64'(s_we_o),  64'(e_we));
    chk("s_adr",   64'(s_adr_o), 64'(e_adr));
    chk("s_sel",   64'(s_sel_o), 64'(e_sel));
    chk("s_dat_o", 64'(s_dat_o), 64'(e_dat));
    if (m_err_o[0]) err_q.push_back(cyc_n);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k]  = we;
    m_adr[k*32 +: 32] = adr;
    m_sel[k*4 +: 4]   = sel;
    m_dat[k*32 +: 32] = dat;
  endtask

  initial begin : stim
    int g;
    int big_g;
    int exp_order [4] = '{0, 1, 0, 1};

    // Reset state
    repeat (3) tick();
    chk("rst_gnt",  64'(m_gnt_o), 64'(0));
    chk("rst_scyc", 64'(s_cyc_o), 64'(0));
    rst = 1'b1;
    tick();

    // 1: single master, slave acks two cycles after the request
    set_m(0, 1, 1, 1, 32'h3000_0010, 4'hF, 32'hA5A5_0001);
    tick();
    chk("t1_gnt", 64'(m_gnt_o), 64'(2'b01));
    chk("t1_adr", 64'(s_adr_o), 64'(32'h3000_0010));
    tick();
    s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack", 64'(m_ack_o), 64'(2'b01));
    chk("t1_dat", 64'(m_dat_o), 64'(32'hDEAD_BEEF));
    tick();
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    tick();
    chk("t1_rel", 64'(m_gnt_o), 64'(0));

    // 2: simultaneous requests after reset alternate 0,1,0,1
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    set_m(0, 1, 1, 0, 32'h1000_0000, 4'hF, 32'h0000_0000);
    set_m(1, 1, 1, 1, 32'h2000_0000, 4'hC, 32'h1234_5678);
    for (int r = 0; r < 4; r++) begin
      tick();
      g = (m_gnt_o == 2'b01) ? 0 : (m_gnt_o == 2'b10) ? 1 : -1;
      chk("t2_order", 64'(g), 64'(exp_order[r]));
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      if (g >= 0) begin
        m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
      end
      tick();
      chk("t2_dead", 64'(m_gnt_o), 64'(0));
      if (g >= 0) begin
        m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
      end
    end
    m_cyc = '0; m_stb = '0;
    tick(); tick();

    // 3: master 1 burst is not pre-empted by master 0
    set_m(1, 1, 1, 1, 32'h4000_0000, 4'h3, 32'h1111_2222);
    tick();
    chk("t3_gnt1", 64'(m_gnt_o), 64'(2'b10));
    set_m(0, 1, 1, 0, 32'h5000_0000, 4'hF, 32'h0);
    for (int b = 0; b < 4; b++) begin
      m_adr[32 +: 32] = 32'h4000_0000 + 32'(4 * b);
      s_ack = 1'b1;
      #1;
      chk("t3_burst_gnt", 64'(m_gnt_o), 64'(2'b10));
      chk("t3_burst_ack", 64'(m_ack_o), 64'(2'b10));
      tick();
      s_ack = 1'b0;
      if (b == 1) begin
        m_stb[1] = 1'b0;
        tick();
        chk("t3_gap_gnt", 64'(m_gnt_o), 64'(2'b10));
        m_stb[1] = 1'b1;
      end
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    chk("t3_dead", 64'(m_gnt_o), 64'(0));
    tick();
    chk("t3_gnt0", 64'(m_gnt_o), 64'(2'b01));
    big_g = cyc_n;
    err_q.delete();

    // 4: stalled strobe, watchdog fires every TIMEOUT cycles
    repeat (34) tick();
    chk("t4_npulse", 64'(err_q.size()), 64'(2));
    chk("t4_first",  64'((err_q.size() > 0) ? err_q[0] - big_g : -1), 64'(16));
    chk("t4_second", 64'((err_q.size() > 1) ? err_q[1] - big_g : -1), 64'(32));
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick(); tick();

    // 5: slave error on the expiry cycle gives exactly one pulse
    set_m(0, 1, 1, 0, 32'h6000_0000, 4'hF, 32'h0);
    tick();
    chk("t5_gnt", 64'(m_gnt_o), 64'(2'b01));
    big_g = cyc_n;
    err_q.delete();
    repeat (15) tick();
    s_err = 1'b1;
    #1;
    chk("t5_err_now", 64'(m_err_o), 64'(2'b01));
    tick();
    s_err = 1'b0;
    #1;
    chk("t5_no_dup", 64'(m_err_o), 64'(2'b00));
    tick();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
    chk("t5_npulse", 64'(err_q.size()), 64'(1));
    chk("t5_at",     64'((err_q.size() > 0) ? err_q[0] - big_g : -1), 64'(15));

    // 6: asynchronous reset mid-transfer
    set_m(0, 1, 1, 0, 32'h7000_0000, 4'hF, 32'h0);
    set_m(1, 1, 1, 1, 32'h8000_0000, 4'hF, 32'hCAFE_0000);
    tick();
    chk("t6_gnt1", 64'(m_gnt_o), 64'(2'b10));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_gnt", 64'(m_gnt_o), 64'(0));
    chk("t6_async_cyc", 64'(s_cyc_o), 64'(0));
    chk("t6_async_stb", 64'(s_stb_o), 64'(0));
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t6_post_gnt", 64'(m_gnt_o), 64'(2'b01));
    m_cyc = '0; m_stb = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
